// File: rtl/usb_line_capture.sv
// usb_line_capture: samples the asynchronous USB D+/D- pair, waits for the
// line to leave the idle J state while armed, then streams line records into
// a first-word-fall-through FIFO with sticky overflow and drop counting.
// Build option: define USB_CAP_RLE_EN for run-length records
// {run[5:0], dp, dn}; otherwise one raw record {6'b0, dp, dn} per sample.
module usb_line_capture #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [1:0]  J_STATE    = 2'b10
) (
  input  logic        clk_samp,
  input  logic        RSTB,
  input  logic        usb_dp,
  input  logic        usb_dn,
  input  logic        arm,
  input  logic        clr,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        capturing,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [1:0]  sync1, sync2, line;
  logic        trig;
  logic        push, pop, push_ok, drop, full, empty;
  logic [7:0]  push_data;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

`ifdef USB_CAP_RLE_EN
  logic [5:0]  run_cnt;
  logic [1:0]  run_line;
  logic        run_emit;
`endif

  // Two-flop synchronizer; idles at J so reset never looks like a trigger
  always_ff @(posedge clk_samp) begin
    if (RSTB) begin
      sync1 <= J_STATE;
      sync2 <= J_STATE;
    end else begin
      sync1 <= {usb_dp, usb_dn};
      sync2 <= sync1;
    end
  end

  assign line = sync2;
  assign trig = (state == WAIT_TRIG) && arm && (line != J_STATE);

`ifdef USB_CAP_RLE_EN
  // A run closes when the line changes or it already holds 64 samples
  assign run_emit = (line != run_line) || (run_cnt == 6'd63);

  // Run tracker: the triggering sample opens the first run
  always_ff @(posedge clk_samp) begin
    if (RSTB) begin
      run_cnt  <= '0;
      run_line <= J_STATE;
    end else if (trig) begin
      run_cnt  <= '0;
      run_line <= line;
    end else if (state == CAPTURE) begin
      if (run_emit) begin
        run_cnt  <= '0;
        run_line <= line;
      end else begin
        run_cnt  <= run_cnt + 6'd1;
      end
    end
  end
`endif

  // Capture state register
  always_ff @(posedge clk_samp) begin
    if (RSTB) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and record generation
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = {6'b0, line};
    unique case (state)
      IDLE: begin
        if (arm) state_nxt = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (!arm) begin
          state_nxt = IDLE;
        end else if (trig) begin
          state_nxt = CAPTURE;
`ifndef USB_CAP_RLE_EN
          push      = 1'b1;
`endif
        end
      end
      CAPTURE: begin
        if (!arm) state_nxt = FLUSH;
`ifdef USB_CAP_RLE_EN
        push      = run_emit;
        push_data = {run_cnt, run_line};
`else
        push      = 1'b1;
`endif
      end
      FLUSH: begin
        state_nxt = IDLE;
`ifdef USB_CAP_RLE_EN
        push      = 1'b1;
        push_data = {run_cnt, run_line};
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign capturing = (state == CAPTURE);

  // FIFO bookkeeping; a pop frees the slot for a same-cycle push when full
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign pop     = out_valid && out_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk_samp) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk_samp) begin
    if (RSTB) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr];

  // Sticky overflow and saturating drop counter; a drop beats a clear
  always_ff @(posedge clk_samp) begin
    if (RSTB) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      overflow <= drop;
      drop_cnt <= {15'b0, drop};
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_usb_line_capture.sv
// Bench for usb_line_capture: directed table and corner sequences plus a
// randomized run checked against a queue-based reference model.
module tb_usb_line_capture;

  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstb, dp, dn, arm, clr, rdy;
  logic [7:0]  out_data;
  logic        out_valid, capturing, overflow;
  logic [15:0] drop_cnt;

  int nchk = 0;
  int nfail = 0;

  usb_line_capture #(.FIFO_DEPTH(DEPTH), .J_STATE(J)) dut (
    .clk_samp (clk),
    .RSTB     (rstb),
    .usb_dp   (dp),
    .usb_dn   (dn),
    .arm      (arm),
    .clr      (clr),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(rdy),
    .capturing(capturing),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       arm;
    logic [1:0] pins;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_cap;
  } vec_t;

  // Reference model state: line delay pipe, capture phase flags, record queue
  logic [1:0] m_hist [2];
  logic [7:0] m_q [$];
  bit         m_wait, m_cap, m_flush, m_ovf;
  int         m_drop;

  task automatic model_step(input bit rst, input bit a, input logic [1:0] p,
                            input bit r, input bit c);
    logic [1:0] ln;
    bit         do_push, do_pop, do_drop;
    if (rst) begin
      m_q.delete();
      m_hist[0] = J;
      m_hist[1] = J;
      m_wait = 0; m_cap = 0; m_flush = 0; m_ovf = 0; m_drop = 0;
      return;
    end
    ln      = m_hist[0];
    do_push = m_cap || (m_wait && a && ln != J);
    do_pop  = (m_q.size() > 0) && r;
    do_drop = do_push && (m_q.size() == DEPTH) && !do_pop;
    if (do_pop) void'(m_q.pop_front());
    if (do_push && !do_drop) m_q.push_back({6'b0, ln});
    if (c) begin
      m_ovf  = do_drop;
      m_drop = do_drop ? 1 : 0;
    end else if (do_drop) begin
      m_ovf = 1;
      if (m_drop < 65535) m_drop++;
    end
    if (m_cap) begin
      if (!a) begin m_cap = 0; m_flush = 1; end
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_wait) begin
      if (!a) m_wait = 0;
      else if (ln != J) begin m_wait = 0; m_cap = 1; end
    end else if (a) begin
      m_wait = 1;
    end
    m_hist[0] = m_hist[1];
    m_hist[1] = p;
  endtask

  initial begin
    vec_t       tbl [22];
    logic [7:0] rle_exp [3];

    rstb = 1'b1; arm = 1'b0; clr = 1'b0; rdy = 1'b1;
    {dp, dn} = J;

    // Reset state
    cycle(); cycle();
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_data", 16'(out_data), 16'h0);
    chk("rst_cap", 16'(capturing), 16'h0);
    chk("rst_ovf", 16'(overflow), 16'h0);
    chk("rst_drop", drop_cnt, 16'h0);
    rstb = 1'b0;

`ifndef USB_CAP_RLE_EN
    // J x10, K x3, SE0 x2, then J; arm drops at vector 20
    for (int i = 0; i < 22; i++) begin
      tbl[i].arm       = (i < 20);
      tbl[i].pins      = (i >= 10 && i < 13) ? K : (i >= 13 && i < 15) ? 2'b00 : J;
      tbl[i].exp_valid = (i >= 12 && i <= 20);
      tbl[i].exp_cap   = (i >= 12 && i < 20);
      tbl[i].exp_data  = (i >= 12 && i <= 14) ? 8'h01 :
                         (i >= 15 && i <= 16) ? 8'h00 : 8'h02;
    end
    for (int i = 0; i < 22; i++) begin
      arm = tbl[i].arm;
      {dp, dn} = tbl[i].pins;
      rdy = 1'b1;
      cycle();
      chk($sformatf("tbl%0d_valid", i), 16'(out_valid), 16'(tbl[i].exp_valid));
      if (tbl[i].exp_valid)
        chk($sformatf("tbl%0d_data", i), 16'(out_data), 16'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_cap", i), 16'(capturing), 16'(tbl[i].exp_cap));
    end

    // Overflow: 20 records into a 16-deep FIFO with no consumer
    rdy = 1'b0; arm = 1'b0; {dp, dn} = K;
    repeat (3) cycle();
    arm = 1'b1;
    repeat (20) cycle();
    arm = 1'b0;
    repeat (2) cycle();
    chk("ovf_flag", 16'(overflow), 16'h1);
    chk("ovf_drop", drop_cnt, 16'd4);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("clr_flag", 16'(overflow), 16'h0);
    chk("clr_drop", drop_cnt, 16'd0);
    rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d_valid", i), 16'(out_valid), 16'h1);
      chk($sformatf("drain%0d_data", i), 16'(out_data), 16'h01);
      cycle();
    end
    chk("drain_empty", 16'(out_valid), 16'h0);

    // Full FIFO with a consumer every cycle never drops
    rdy = 1'b0; arm = 1'b1;
    repeat (17) cycle();
    chk("full_drop", drop_cnt, 16'd0);
    rdy = 1'b1;
    repeat (10) cycle();
    chk("fullrw_drop", drop_cnt, 16'd0);
    chk("fullrw_ovf", 16'(overflow), 16'h0);
    chk("fullrw_valid", 16'(out_valid), 16'h1);
    // clr on the same edge as a drop
    rdy = 1'b0; clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("clrdrop_ovf", 16'(overflow), 16'h1);
    chk("clrdrop_cnt", drop_cnt, 16'd1);
    arm = 1'b0;
    repeat (2) cycle();
    chk("flush_drop", drop_cnt, 16'd2);

    // Reset with records queued
    rstb = 1'b1;
    cycle();
    rstb = 1'b0;
    chk("rstq_valid", 16'(out_valid), 16'h0);
    chk("rstq_data", 16'(out_data), 16'h0);
    chk("rstq_drop", drop_cnt, 16'd0);
    chk("rstq_ovf", 16'(overflow), 16'h0);
    chk("rstq_cap", 16'(capturing), 16'h0);
`else
    // K x5 then J; 71 J samples reach the line before arm drops
    rdy = 1'b0; arm = 1'b1; {dp, dn} = J;
    repeat (2) cycle();
    {dp, dn} = K;
    repeat (5) cycle();
    {dp, dn} = J;
    repeat (72) cycle();
    arm = 1'b0;
    repeat (2) cycle();
    rle_exp[0] = 8'h11; rle_exp[1] = 8'hFE; rle_exp[2] = 8'h1A;
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rle%0d_valid", i), 16'(out_valid), 16'h1);
      chk($sformatf("rle%0d_data", i), 16'(out_data), 16'(rle_exp[i]));
      cycle();
    end
    chk("rle_empty", 16'(out_valid), 16'h0);
`endif

    // arm withdrawn in WAIT_TRIG while the line is already non-J
    rdy = 1'b1; arm = 1'b0; {dp, dn} = K;
    repeat (3) cycle();
    arm = 1'b1;
    cycle();
    arm = 1'b0;
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("abort%0d_valid", i), 16'(out_valid), 16'h0);
      chk($sformatf("abort%0d_cap", i), 16'(capturing), 16'h0);
    end

`ifndef USB_CAP_RLE_EN
    // Randomized traffic against the reference model
    begin
      int rdy_pct;
      rstb = 1'b1; arm = 1'b0; clr = 1'b0; rdy = 1'b0; {dp, dn} = J;
      model_step(1'b1, arm, {dp, dn}, rdy, clr);
      cycle();
      rdy_pct = 50;
      for (int n = 0; n < 3000; n++) begin
        if (n % 200 == 0) rdy_pct = $urandom_range(0, 100);
        rstb = ($urandom_range(0, 599) == 0);
        if ($urandom_range(0, 19) == 0) arm = ~arm;
        {dp, dn} = ($urandom_range(0, 3) < 2) ? J : 2'($urandom_range(0, 3));
        rdy = ($urandom_range(0, 99) < rdy_pct);
        clr = ($urandom_range(0, 49) == 0);
        model_step(rstb, arm, {dp, dn}, rdy, clr);
        cycle();
        chk("rnd_valid", 16'(out_valid), 16'(m_q.size() != 0));
        if (m_q.size() != 0) chk("rnd_data", 16'(out_data), 16'(m_q[0]));
        chk("rnd_cap", 16'(capturing), 16'(m_cap));
        chk("rnd_ovf", 16'(overflow), 16'(m_ovf));
        chk("rnd_drop", drop_cnt, m_drop[15:0]);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/usb_line_capture.md
USB_LINE_CAPTURE -- requirements
Module: usb_line_capture

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning output FIFO depth in bytes (power of two, 4..256).
REQ-002 SHALL have parameter J_STATE, default 2'b10, meaning idle line state {dp,dn} (full-speed J).
REQ-003 SHALL have port clk_samp  input  1  sample clock; all logic on rising edge.
REQ-004 SHALL have port RSTB  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port usb_dp  input  1  asynchronous D+ line.
REQ-006 SHALL have port usb_dn  input  1  asynchronous D- line.
REQ-007 SHALL have port arm  input  1  capture enable level.
REQ-008 SHALL have port clr  input  1  one-cycle pulse clearing overflow and drop_cnt.
REQ-009 SHALL have port out_data  output  8  captured record.
REQ-010 SHALL have port out_valid  output  1  out_data holds a record.
REQ-011 SHALL have port out_ready  input  1  consumer accepts record when out_valid is high.
REQ-012 SHALL have port capturing  output  1  high in CAPTURE state.
REQ-013 SHALL have port overflow  output  1  sticky FIFO-overflow flag.
REQ-014 SHALL have port drop_cnt  output  16  count of dropped records, saturating at 16'hFFFF.

Function
REQ-015 SHALL pass usb_dp/usb_dn through a 2-flop synchronizer; line = {dp_sync, dn_sync}.
REQ-016 SHALL implement states IDLE, WAIT_TRIG, CAPTURE, FLUSH.
REQ-017 IDLE->WAIT_TRIG when arm=1; WAIT_TRIG->CAPTURE on first cycle line != J_STATE; CAPTURE->FLUSH when arm=0; FLUSH->IDLE after one cycle; WAIT_TRIG->IDLE when arm=0.
REQ-018 Raw record format SHALL be {6'b0, dp, dn}, one record per clk_samp in CAPTURE, starting with the triggering sample.
REQ-019 Pin value presented before edge n SHALL be the synchronized value after edge n+1 and written to FIFO at edge n+2; out_valid SHALL rise after edge n+2 when FIFO was empty.
REQ-020 FIFO SHALL be first-word-fall-through; pop occurs on edge where out_valid & out_ready.
REQ-021 Push while full and no simultaneous pop SHALL drop the record, set overflow, increment drop_cnt (saturating).
REQ-022 Simultaneous push and pop while full SHALL accept the push with no overflow.
REQ-023 Empty FIFO SHALL drive out_valid=0; out_data SHALL not be relied upon.
REQ-024 clr SHALL zero overflow and drop_cnt; clr coincident with a drop SHALL leave overflow=1, drop_cnt=1.
REQ-025 FIFO contents SHALL survive arm deassertion and remain drainable in IDLE.
REQ-026 Re-arming SHALL not flush FIFO; new records append.

Reset
REQ-027 While RSTB=1 at an edge: state=IDLE, FIFO empty, out_valid=0, out_data=8'h00, capturing=0, overflow=0, drop_cnt=0, synchronizer flops=J_STATE.
REQ-028 RSTB mid-capture SHALL discard FIFO contents and any pending run, with no partial record emitted.

Configuration
REQ-029 Macro USB_CAP_RLE_EN SHALL select run-length mode when defined.
REQ-030 With USB_CAP_RLE_EN: record = {run[5:0], dp, dn}, run = sample count minus 1; record emitted on line change (for previous state) or when run reaches 63; FLUSH emits the pending run; max one push per cycle.
REQ-031 Without USB_CAP_RLE_EN: raw records per REQ-018; FLUSH pushes nothing.

Verification
REQ-032 Raw: arm=1, line J for 10 cycles then K (01) 3 cycles, SE0 (00) 2 cycles, out_ready=1 -> records 01,01,01,00,00 then 10 ongoing; capturing rises with first 01.
REQ-033 Overflow: FIFO_DEPTH=16, out_ready=0, 20 capture cycles -> 16 records held, overflow=1, drop_cnt=4; clr -> both 0, FIFO still 16.
REQ-034 Full with out_ready=1 each cycle -> no drop, drop_cnt stays 0.
REQ-035 RLE: K for 5 cycles, J for 70, then arm=0 -> records 8'h11 (run 4,K), 8'hFE (run 63,J), 8'h1A (run 6,J flushed).
REQ-036 Reset: RSTB=1 while 8 records queued -> next cycle out_valid=0, drop_cnt=0, state IDLE; arm=0 in WAIT_TRIG -> IDLE, no records.
